// File: rtl/imem_loader.sv
// Host byte stream -> little-endian 32-bit IMEM words; core held in reset until the image completes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  IM_WE,
  output logic [ADDR_WIDTH-1:0] IM_Addr,
  output logic [31:0]           IM_WData,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [7:0]            len_lo_q;
  logic [ADDR_WIDTH-1:0] last_idx_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           asm_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  core_rst_n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q;
`endif

  logic        accept;
  logic        idle_like;
  logic        last_byte;
  logic [15:0] len_w;

  assign accept    = in_valid & in_ready;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);
  assign len_w     = {in_data, len_lo_q};
  assign last_byte = accept && (byte_idx_q == 2'd3) && (word_idx_q == last_idx_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_LO;
      S_LEN_LO:              if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_w == 16'd0)              state_d = S_FIN;
          else if ({1'b0, len_w} > CAP)    state_d = S_ERR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA:                if (last_byte) state_d = S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:                 if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
`endif
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: in_ready = 1'b1;
      S_DONE:                            done     = 1'b1;
      S_ERR:                             error    = 1'b1;
      default:                           ;
    endcase
    busy = in_ready;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      len_lo_q     <= '0;
      last_idx_q   <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      // Release the core one cycle after DONE is entered, drop it as soon as a reload starts.
      core_rst_n_q <= (state_q == S_DONE) && (state_d == S_DONE);
      if (idle_like && start) begin
        word_idx_q <= '0;
        byte_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q      <= '0;
`endif
      end
      if (accept) begin
        case (state_q)
          S_LEN_LO: len_lo_q   <= in_data;
          S_LEN_HI: last_idx_q <= ADDR_WIDTH'(len_w - 16'd1);
          S_DATA: begin
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_q ^ in_data;
`endif
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                we_q       <= 1'b1;
                addr_q     <= word_idx_q;
                wdata_q    <= {in_data, asm_q};
                word_idx_q <= word_idx_q + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign IM_WE      = we_q;
  assign IM_Addr    = addr_q;
  assign IM_WData   = wdata_q;
  assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IMEM writes queued as bytes are driven, checked by a write monitor.
module tb_imem_loader;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready, IM_WE, core_rst_n, busy, done, error;
  logic [AW-1:0] IM_Addr;
  logic [31:0]   IM_WData;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .IM_WE(IM_WE), .IM_Addr(IM_Addr), .IM_WData(IM_WData),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           e;
  logic [7:0]    img[$];
  int            checks = 0;
  int            passes = 0;
  int            wr_count = 0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge CLK) begin
    if (IM_WE === 1'b1) begin
      wr_count++;
      last_addr = IM_Addr;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr=%0h data=%08h, none expected", IM_Addr, IM_WData);
      end else begin
        e = exp_q.pop_front();
        if ({IM_Addr, IM_WData} !== {e.a, e.d})
          $display("FAIL write_data: got addr=%0h data=%08h, expected addr=%0h data=%08h",
                   IM_Addr, IM_WData, e.a, e.d);
        else passes++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) begin
      in_valid = 1'b0;
      tick($urandom_range(0, 3));
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin tick(1); t++; end
    if (t >= 100) begin
      checks++;
      $display("FAIL in_ready_timeout: in_ready stayed 0, expected 1");
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  // Sends length, img data (queueing expected words) and, when compiled in, the correct checksum.
  task automatic send_image(input int n, input bit gaps, input int pulse_at);
    logic [15:0] len;
    logic [7:0]  x = 8'h00;
    len = 16'(n);
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
    for (int i = 0; i < 4 * n; i++) begin
      if (i == pulse_at) pulse_start();
      x ^= img[i];
      if (i % 4 == 3) exp_q.push_back('{a: AW'(i / 4), d: {img[i], img[i-1], img[i-2], img[i-3]}});
      send_byte(img[i], gaps);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x, gaps);
`endif
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 50) begin tick(1); t++; end
    checks++;
    if (t >= 50) $display("FAIL end_timeout: done=%0b error=%0b, expected one of them 1", done, error);
    else passes++;
  endtask

  task automatic load_basic_img();
    img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, IM_WE, IM_Addr, IM_WData, core_rst_n, busy, done, error} !== '0)
      $display("FAIL reset_outputs: got rdy=%0b we=%0b addr=%0h wd=%08h crst=%0b busy=%0b done=%0b err=%0b, expected all 0",
               in_ready, IM_WE, IM_Addr, IM_WData, core_rst_n, busy, done, error);
    else passes++;
    @(posedge CLK); #1; RST = 1'b1;
    tick(1);
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h05, 0);
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_pre_busy: got %0b, expected 1", busy);
    else passes++;
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({in_ready, IM_WE, IM_Addr, IM_WData, core_rst_n, busy, done, error} !== '0)
      $display("FAIL reset_mid_data: got rdy=%0b we=%0b busy=%0b crst=%0b, expected all 0",
               in_ready, IM_WE, busy, core_rst_n);
    else passes++;
    @(posedge CLK); #1; RST = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    int w0 = wr_count;
    load_basic_img();
    pulse_start();
    send_image(2, 0, -1);
    checks++;
    if ({done, core_rst_n} !== 2'b10)
      $display("FAIL basic_done_edge: got done=%0b core_rst_n=%0b, expected done=1 core_rst_n=0", done, core_rst_n);
    else passes++;
`ifndef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if (IM_WE !== 1'b1) $display("FAIL basic_last_we: got %0b, expected 1", IM_WE);
    else passes++;
`endif
    tick(1);
    checks++;
    if ({done, core_rst_n, in_ready, busy, error, IM_WE} !== 6'b110000)
      $display("FAIL basic_final: got done=%0b crst=%0b rdy=%0b busy=%0b err=%0b we=%0b, expected 1 1 0 0 0 0",
               done, core_rst_n, in_ready, busy, error, IM_WE);
    else passes++;
    checks++;
    if ({IM_Addr, IM_WData} !== {8'h01, 32'h0000006F})
      $display("FAIL basic_hold: got addr=%0h data=%08h, expected addr=1 data=0000006f", IM_Addr, IM_WData);
    else passes++;
    checks++;
    if (wr_count - w0 !== 2 || exp_q.size() != 0)
      $display("FAIL basic_count: got %0d writes (%0d pending), expected 2 (0)", wr_count - w0, exp_q.size());
    else passes++;
  endtask

  task automatic test_zero_len();
    int w0 = wr_count;
    pulse_start();
    checks++;
    if ({busy, done, core_rst_n} !== 3'b100)
      $display("FAIL zero_start: got busy=%0b done=%0b crst=%0b, expected 1 0 0", busy, done, core_rst_n);
    else passes++;
    send_image(0, 0, -1);
    wait_end();
    tick(2);
    checks++;
    if ({done, error, core_rst_n} !== 3'b101 || wr_count != w0)
      $display("FAIL zero_len: got done=%0b err=%0b crst=%0b writes=%0d, expected 1 0 1 writes=0",
               done, error, core_rst_n, wr_count - w0);
    else passes++;
  endtask

  task automatic test_overflow();
    int w0 = wr_count;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if ({error, done, in_ready, core_rst_n} !== 4'b1000)
      $display("FAIL ovf_257: got err=%0b done=%0b rdy=%0b crst=%0b, expected 1 0 0 0",
               error, done, in_ready, core_rst_n);
    else passes++;
    in_valid = 1'b1;
    tick(4);
    in_valid = 1'b0;
    checks++;
    if (wr_count != w0 || core_rst_n !== 1'b0 || error !== 1'b1)
      $display("FAIL ovf_hold: got writes=%0d crst=%0b err=%0b, expected 0 0 1", wr_count - w0, core_rst_n, error);
    else passes++;
    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back(8'($urandom));
    w0 = wr_count;
    pulse_start();
    send_image(256, 0, -1);
    wait_end();
    tick(2);
    checks++;
    if (wr_count - w0 != 256 || last_addr !== 8'hFF || done !== 1'b1 || exp_q.size() != 0)
      $display("FAIL full_256: got writes=%0d last=%0h done=%0b pending=%0d, expected 256 ff 1 0",
               wr_count - w0, last_addr, done, exp_q.size());
    else passes++;
  endtask

  task automatic test_handshake();
    int w0 = wr_count;
    load_basic_img();
    pulse_start();
    send_image(2, 1, 3);
    wait_end();
    tick(2);
    checks++;
    if ({done, error, core_rst_n} !== 3'b101 || wr_count - w0 != 2 || exp_q.size() != 0)
      $display("FAIL handshake: got done=%0b err=%0b crst=%0b writes=%0d pending=%0d, expected 1 0 1 2 0",
               done, error, core_rst_n, wr_count - w0, exp_q.size());
    else passes++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    load_basic_img();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    exp_q.push_back('{a: 8'h00, d: 32'h00A00513});
    exp_q.push_back('{a: 8'h01, d: 32'h0000006F});
    foreach (img[i]) send_byte(img[i], 0);
    send_byte(8'h00, 0);
    tick(1);
    checks++;
    if ({error, done, core_rst_n} !== 3'b100 || exp_q.size() != 0)
      $display("FAIL chk_bad: got err=%0b done=%0b crst=%0b pending=%0d, expected 1 0 0 0",
               error, done, core_rst_n, exp_q.size());
    else passes++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    #12;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_handshake();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    tick(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
